// File: rtl/glyph_recognizer.sv
`default_nettype none
// ============================================================================
// Module   : glyph_recognizer (with its digit font ROM, number_rom)
// Brief    : Collects a 7x8 column bitmap and reports the nearest digit glyph.
// Revision : 1.0
// ============================================================================

module number_rom (
    input  logic [3:0]      x,
    output logic [0:6][7:0] cols
);
    always_comb begin
        cols = '0;
        case (x)
            4'd0: cols = {8'h00, 8'h3E, 8'h51, 8'h49, 8'h45, 8'h3E, 8'h00};
            4'd1: cols = {8'h00, 8'h00, 8'h42, 8'h7F, 8'h40, 8'h00, 8'h00};
            4'd2: cols = {8'h00, 8'h42, 8'h61, 8'h51, 8'h49, 8'h46, 8'h00};
            4'd3: cols = {8'h00, 8'h22, 8'h41, 8'h49, 8'h49, 8'h36, 8'h00};
            4'd4: cols = {8'h00, 8'h18, 8'h14, 8'h12, 8'h7F, 8'h10, 8'h00};
            4'd5: cols = {8'h00, 8'h27, 8'h45, 8'h45, 8'h45, 8'h39, 8'h00};
            4'd6: cols = {8'h00, 8'h3E, 8'h49, 8'h49, 8'h49, 8'h32, 8'h00};
            4'd7: cols = {8'h00, 8'h61, 8'h11, 8'h09, 8'h05, 8'h03, 8'h00};
            4'd8: cols = {8'h00, 8'h36, 8'h49, 8'h49, 8'h49, 8'h36, 8'h00};
            4'd9: cols = {8'h00, 8'h26, 8'h49, 8'h49, 8'h49, 8'h3E, 8'h00};
            default: cols = '0;
        endcase
    end
endmodule

module glyph_recognizer #(
    parameter int MAX_ERR = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       col_valid,
    input  logic       col_sof,
    input  logic [7:0] col_data,
    output logic       col_ready,
    output logic       result_valid,
    output logic [3:0] digit,
    output logic [5:0] distance,
    output logic       match,
    output logic       busy
);
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SCAN    = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [6:0] c_max_err = 7'(MAX_ERR);

    state_t          r_state;
    state_t          w_state_next;
    logic [0:6][7:0] r_frame;
    logic [2:0]      r_col_idx;
    logic [3:0]      r_cand;
    logic [5:0]      r_best_dist;
    logic [3:0]      r_best_digit;
    logic [3:0]      r_digit;
    logic [5:0]      r_distance;
    logic            r_match;

    logic [3:0]      w_rom_x;
    logic [0:6][7:0] w_glyph;
    logic [55:0]     w_diff;
    logic [5:0]      w_dist;
    logic            w_accept;
    logic            w_last_col;
    logic [5:0]      w_best_dist_nx;
    logic [3:0]      w_best_digit_nx;

    // ROM address is parked at 0 outside SCAN so codes 10..15 never appear.
    assign w_rom_x = (r_state == SCAN) ? r_cand : 4'd0;

    number_rom u_rom (
        .x    (w_rom_x),
        .cols (w_glyph)
    );

    assign w_accept   = col_valid && col_ready;
    assign w_last_col = w_accept && !col_sof && (r_col_idx == 3'd6);

    always_comb begin
        w_diff = r_frame ^ w_glyph;
        w_dist = '0;
        for (int i = 0; i < 56; i++) begin
            w_dist = w_dist + {5'd0, w_diff[i]};
        end
    end

    // Strict compare so equal distances keep the lower (earlier) digit.
    always_comb begin
        w_best_dist_nx  = r_best_dist;
        w_best_digit_nx = r_best_digit;
        if (w_dist < r_best_dist) begin
            w_best_dist_nx  = w_dist;
            w_best_digit_nx = r_cand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            COLLECT: if (w_last_col) w_state_next = SCAN;
            SCAN:    if (r_cand == 4'd9) w_state_next = DONE;
            DONE:    w_state_next = COLLECT;
            default: w_state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame      <= '0;
            r_col_idx    <= '0;
            r_cand       <= '0;
            r_best_dist  <= 6'd63;
            r_best_digit <= '0;
            r_digit      <= '0;
            r_distance   <= '0;
            r_match      <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        if (col_sof) begin
                            r_frame[0] <= col_data;
                            r_col_idx  <= 3'd1;
                        end else begin
                            r_frame[r_col_idx] <= col_data;
                            r_col_idx          <= r_col_idx + 3'd1;
                        end
                    end
                    if (w_last_col) begin
                        r_col_idx    <= '0;
                        r_cand       <= '0;
                        r_best_dist  <= 6'd63;
                        r_best_digit <= '0;
                    end
                end
                SCAN: begin
                    r_best_dist  <= w_best_dist_nx;
                    r_best_digit <= w_best_digit_nx;
                    if (r_cand == 4'd9) begin
                        r_cand     <= '0;
                        r_digit    <= w_best_digit_nx;
                        r_distance <= w_best_dist_nx;
                        r_match    <= ({1'b0, w_best_dist_nx} <= c_max_err);
                    end else begin
                        r_cand <= r_cand + 4'd1;
                    end
                end
                DONE: begin
                    r_col_idx <= '0;
                end
                default: begin
                    r_col_idx <= '0;
                end
            endcase
        end
    end

    assign col_ready    = (r_state == COLLECT);
    assign result_valid = (r_state == DONE);
    assign busy         = (r_state == SCAN) || (r_state == DONE);
    assign digit        = r_digit;
    assign distance     = r_distance;
    assign match        = r_match;

endmodule
`default_nettype wire

// File: tb/tb_glyph_recognizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_glyph_recognizer
// Brief    : Directed self-checking bench for glyph_recognizer (MAX_ERR 0 and 2).
// Revision : 1.0
// ============================================================================

module tb_glyph_recognizer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       col_valid = 1'b0;
    logic       col_sof = 1'b0;
    logic [7:0] col_data = 8'h00;

    logic       col_ready, result_valid, match, busy;
    logic [3:0] digit;
    logic [5:0] distance;
    logic       col_ready2, result_valid2, match2, busy2;
    logic [3:0] digit2;
    logic [5:0] distance2;

    int n_checks = 0;
    int n_errors = 0;

    glyph_recognizer #(.MAX_ERR(0)) dut (
        .clk(clk), .rst(rst), .col_valid(col_valid), .col_sof(col_sof),
        .col_data(col_data), .col_ready(col_ready), .result_valid(result_valid),
        .digit(digit), .distance(distance), .match(match), .busy(busy)
    );

    glyph_recognizer #(.MAX_ERR(2)) dut2 (
        .clk(clk), .rst(rst), .col_valid(col_valid), .col_sof(col_sof),
        .col_data(col_data), .col_ready(col_ready2), .result_valid(result_valid2),
        .digit(digit2), .distance(distance2), .match(match2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_col(input logic [7:0] d, input logic sof);
        int n;
        col_valid = 1'b1;
        col_data  = d;
        col_sof   = sof;
        n = 0;
        while (!col_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_errors++;
            $error("FAIL ready_timeout: observed col_ready 0 expected 1");
        end
        tick();
        col_valid = 1'b0;
        col_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c0, c1, c2, c3, c4, c5, c6);
        send_col(c0, 1'b1);
        send_col(c1, 1'b0);
        send_col(c2, 1'b0);
        send_col(c3, 1'b0);
        send_col(c4, 1'b0);
        send_col(c5, 1'b0);
        send_col(c6, 1'b0);
    endtask

    // Sends a frame and checks the fixed T+11 result timing and the result fields.
    task automatic run_frame(input logic [7:0] c0, c1, c2, c3, c4, c5, c6,
                             input logic [3:0] ed, input logic [5:0] edist,
                             input logic em0, input logic em2, input bit hold);
        send_frame(c0, c1, c2, c3, c4, c5, c6);
        if (hold) begin
            col_valid = 1'b1;
            col_data  = 8'hFF;
            col_sof   = 1'b0;
        end
        for (int k = 1; k <= 10; k++) begin
            check("rv_scan", result_valid, 0);
            check("busy_scan", busy, 1);
            check("ready_scan", col_ready, 0);
            tick();
        end
        check("rv_done", result_valid, 1);
        check("ready_done", col_ready, 0);
        check("busy_done", busy, 1);
        check("digit", digit, ed);
        check("distance", distance, edist);
        check("match_e0", match, em0);
        check("digit_e2", digit2, ed);
        check("match_e2", match2, em2);
        tick();
        col_valid = 1'b0;
        check("rv_after", result_valid, 0);
        check("ready_after", col_ready, 1);
        check("busy_after", busy, 0);
        check("digit_hold", digit, ed);
        check("distance_hold", distance, edist);
        tick();
    endtask

    initial begin
        int rv_seen;
        rst = 1'b1;
        tick(); tick(); tick();
        check("rst_ready", col_ready, 1);
        check("rst_rv", result_valid, 0);
        check("rst_digit", digit, 0);
        check("rst_distance", distance, 0);
        check("rst_match", match, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // exact "3"
        run_frame(8'h00, 8'h22, 8'h41, 8'h49, 8'h49, 8'h36, 8'h00, 4'd3, 6'd0, 1'b1, 1'b1, 1'b0);
        // "8" with one flipped bit
        run_frame(8'h00, 8'h36, 8'h49, 8'h4B, 8'h49, 8'h36, 8'h00, 4'd8, 6'd1, 1'b0, 1'b1, 1'b0);
        // equidistant from 6 and 8
        run_frame(8'h00, 8'h3E, 8'h49, 8'h49, 8'h49, 8'h36, 8'h00, 4'd6, 6'd1, 1'b0, 1'b1, 1'b0);

        // reset five cycles into a scan of an "8"
        send_frame(8'h00, 8'h36, 8'h49, 8'h49, 8'h49, 8'h36, 8'h00);
        tick(); tick(); tick(); tick();
        check("midscan_busy", busy, 1);
        rst = 1'b1;
        tick();
        check("rstscan_rv", result_valid, 0);
        check("rstscan_digit", digit, 0);
        check("rstscan_distance", distance, 0);
        check("rstscan_match", match, 0);
        check("rstscan_ready", col_ready, 1);
        check("rstscan_busy", busy, 0);
        rst = 1'b0;
        rv_seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (result_valid) rv_seen++;
            tick();
        end
        check("rstscan_no_result", rv_seen, 0);
        run_frame(8'h00, 8'h61, 8'h11, 8'h09, 8'h05, 8'h03, 8'h00, 4'd7, 6'd0, 1'b1, 1'b1, 1'b0);

        // blank frame
        run_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'd1, 6'd10, 1'b0, 1'b0, 1'b0);

        // abandoned partial frame, then "0" with col_valid held through SCAN/DONE
        send_col(8'hFF, 1'b1);
        send_col(8'hFF, 1'b0);
        send_col(8'hFF, 1'b0);
        send_col(8'hFF, 1'b0);
        check("partial_busy", busy, 0);
        run_frame(8'h00, 8'h3E, 8'h51, 8'h49, 8'h45, 8'h3E, 8'h00, 4'd0, 6'd0, 1'b1, 1'b1, 1'b1);
        // following frame must be unaffected by the held column
        run_frame(8'h00, 8'h22, 8'h41, 8'h49, 8'h49, 8'h36, 8'h00, 4'd3, 6'd0, 1'b1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/glyph_recognizer.md
Name: glyph_recognizer

Overview:
- Inverse of the team's digit font ROM (`number_rom`): takes a 7-column x 8-row bitmap and returns the decimal digit (0-9) it matches.
- Columns arrive one per cycle on a valid/ready stream from the camera/board-scan front end.
- The block stores the frame, scans all ten ROM glyphs sequentially by driving `number_rom` with candidates 0..9, and reports the nearest digit, its Hamming distance and a match flag.
- Used by the self-check path to confirm what is on the LED matrix.

Parameters:
- MAX_ERR, 0: largest Hamming distance (bits, 0..56) still reported as `match=1`.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- col_valid  in  1  `col_data` valid this cycle
- col_sof  in  1  start of frame; qualifies `col_valid`; the accepted column becomes col0
- col_data  in  8  one glyph column; bit0 = top row, same orientation as `number_rom`
- col_ready  out  1  block accepts a column this cycle
- result_valid  out  1  one-cycle pulse, result fields valid
- digit  out  4  nearest digit 0..9
- distance  out  6  Hamming distance from the frame to the glyph of `digit`
- match  out  1  `distance <= MAX_ERR`
- busy  out  1  high in SCAN and DONE

Behaviour:
- Reset (synchronous, active-high): state=COLLECT, col_idx=0, frame buffer cleared, `col_ready=1`, `result_valid=0`, `digit=0`, `distance=0`, `match=0`, `busy=0`. Reset mid-frame or mid-scan discards all progress; no `result_valid` is produced for that frame.
- Handshake: a column is accepted on a rising edge where `col_valid & col_ready`. `col_ready=1` only in COLLECT. `col_valid` outside COLLECT is ignored and no column is dropped into the next frame.
- COLLECT:
  - Accepted column with `col_sof=1` is stored as col0 and sets col_idx=1; this restarts any partial frame.
  - Accepted column with `col_sof=0` is stored at col_idx, and col_idx increments.
  - When col_idx=6 is accepted, go to SCAN with cand=0, best_dist=63, best_digit=0.
  - A 7th column therefore never needs `col_sof`. Partial frames persist indefinitely until completed or restarted.
- SCAN (10 cycles, cand=0..9):
  - `number_rom.x = cand`.
  - dist = popcount(frame XOR {col0..col6 of ROM}), a 56-bit compare with a 6-bit result, computed combinationally in the same cycle.
  - If dist < best_dist (strict), update best_dist and best_digit. Ties keep the lower digit.
  - After cand=9, go to DONE.
- DONE (1 cycle): `result_valid=1`, `digit=best_digit`, `distance=best_dist`, `match=(best_dist<=MAX_ERR)`; next state COLLECT, col_idx=0.
- Output holding: `digit`, `distance` and `match` hold their values until the next DONE. Only `result_valid` pulses.
- Fixed latency: if the 7th column is accepted at the edge ending cycle T, SCAN occupies T+1..T+10 and `result_valid` is high in cycle T+11. `col_ready` returns high in T+12.
- Throughput: one frame per 18 cycles minimum (7 collect, 10 scan, 1 done).
- Unused ROM codes 10..15 are never driven.

Test Plan:
1. Exact match: reset, then send frame 00,22,41,49,49,36,00 (hex, `col_sof` on the first) with MAX_ERR=0 -> `result_valid` 11 cycles after the last accept; `digit=3`, `distance=0`, `match=1`.
2. Near miss: "8" frame 00,36,49,49,49,36,00 with col3 changed to 0x4B -> `digit=8`, `distance=1`; `match=0` at MAX_ERR=0, `match=1` at MAX_ERR=2.
3. Tie break: frame 00,3E,49,49,49,36,00 is distance 1 from both "6" and "8" -> `digit=6`, `distance=1`.
4. Blank frame: all-zero columns -> `digit=1`, `distance=10`, `match=0` (MAX_ERR=0).
5. Restart and backpressure:
   - Send 4 columns, then `col_sof` plus a full "0" frame (00,3E,51,49,45,3E,00) -> `digit=0`, `distance=0`.
   - Hold `col_valid=1` during SCAN and DONE -> `col_ready=0` and the next frame is unaffected.
6. Reset mid-scan: assert `rst` at cycle T+5 of a scan -> no `result_valid`; outputs read 0 the next cycle; `col_ready=1`; a following "7" frame (00,61,11,09,05,03,00) -> `digit=7`, `distance=0`.
